// File: rtl/count_bcd_converter.sv
// ---------------------------------------------------------------------------
// count_bcd_converter
//
// Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble).
// Converts the 8-bit counter value into three BCD digits for the display
// stage, one shift per clock, eight shifts per conversion.
//
// Parameters:
//   AUTO     : 1 = start a new conversion from IDLE every cycle (start
//              ignored); 0 = convert only on start.
//
// Ports:
//   clk      : clock, rising edge.
//   reset    : asynchronous active-low reset.
//   bin      : 8-bit binary value, captured on the accepting edge only.
//   start    : conversion request, sampled in IDLE only.
//   busy     : high while shifting.
//   done     : one-cycle pulse when new digits are valid.
//   hundreds : BCD hundreds digit (0..2).
//   tens     : BCD tens digit (0..9).
//   ones     : BCD ones digit (0..9).
// ---------------------------------------------------------------------------
module count_bcd_converter #(
  parameter bit AUTO = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] bin,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state;
  state_t      state_d;

  logic [7:0]  sr;       // binary bits still to be shifted in
  logic [11:0] acc;      // BCD scratch, three nibbles
  logic [2:0]  cnt;      // shifts completed so far

  logic        accept;   // IDLE edge that launches a conversion
  logic        last;     // SHIFT edge that performs the eighth shift
  logic [11:0] acc_adj;  // acc after per-nibble add-3 correction
  logic [19:0] shifted;  // {acc_adj, sr} shifted left by one

  // Add 3 to a nibble that would overflow past 9 once doubled.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Correction then shift, all on the current register contents.
  always_comb begin
    acc_adj = {add3(acc[11:8]), add3(acc[7:4]), add3(acc[3:0])};
    shifted = {acc_adj, sr} << 1;
  end

  // Next-state logic.
  // NOTE: every signal driven here gets a default first, so no path
  // through the case leaves one unassigned and infers a latch.
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    last    = 1'b0;
    unique case (state)
      IDLE: begin
        if (AUTO || start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == 3'd7) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr       <= '0;
      acc      <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      hundreds <= '0;
      tens     <= '0;
      ones     <= '0;
    end else begin
      done <= 1'b0;  // pulse: only the completion edge raises it
      if (accept) begin
        sr  <= bin;
        acc <= '0;
        cnt <= '0;
      end else if (state == SHIFT) begin
        sr  <= shifted[7:0];
        acc <= shifted[19:8];
        cnt <= cnt + 3'd1;
        if (last) begin
          // Take the digits straight from the final shift so they are
          // valid on the same edge that ends the conversion.
          hundreds <= shifted[19:16];
          tens     <= shifted[15:12];
          ones     <= shifted[11:8];
          done     <= 1'b1;
        end
      end
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_count_bcd_converter.sv
module tb_count_bcd_converter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] bin = '0;
  logic       start = 1'b0;
  logic       busy, done;
  logic [3:0] hundreds, tens, ones;

  logic [7:0] auto_bin = '0;
  logic       a_busy, a_done;
  logic [3:0] a_hundreds, a_tens, a_ones;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  bit overlap = 1'b0;

  always #5 clk = ~clk;

  count_bcd_converter #(.AUTO(1'b0)) u_dut (
    .clk(clk), .reset(reset), .bin(bin), .start(start),
    .busy(busy), .done(done),
    .hundreds(hundreds), .tens(tens), .ones(ones)
  );

  count_bcd_converter #(.AUTO(1'b1)) u_auto (
    .clk(clk), .reset(reset), .bin(auto_bin), .start(1'b0),
    .busy(a_busy), .done(a_done),
    .hundreds(a_hundreds), .tens(a_tens), .ones(a_ones)
  );

  // Count done pulses of the main instance and watch for done with busy.
  always @(posedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (done === 1'b1 && busy === 1'b1) overlap = 1'b1;
  end

  // Present bin with start for one cycle; returns at the negedge after E0.
  task automatic start_conv(input logic [7:0] b);
    bin   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait up to limit negedges for done. cyc = edges since E0 (or -1).
  task automatic wait_done(input int limit, output int cyc,
                           output bit busy_ok, output bit hold_ok);
    logic [11:0] d0;
    d0      = {hundreds, tens, ones};
    cyc     = -1;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = i;
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if ({hundreds, tens, ones} !== d0) hold_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    #10 reset = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++; $display("FAIL reset_flags: busy/done=%b required 00", {busy, done});
    end
    n_cmp++;
    if ({hundreds, tens, ones} !== 12'h000) begin
      n_err++; $display("FAIL reset_digits: %h required 000", {hundreds, tens, ones});
    end
    n_cmp++;
    if ({a_busy, a_done, a_hundreds, a_tens, a_ones} !== 14'h0) begin
      n_err++; $display("FAIL reset_auto: %h required 0", {a_busy, a_done, a_hundreds, a_tens, a_ones});
    end
    #9 reset = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if ({busy, hundreds, tens, ones} !== 13'h0 || done_cnt != 0) begin
      n_err++; $display("FAIL reset_idle: busy=%b digits=%h dones=%0d required 0 000 0",
                        busy, {hundreds, tens, ones}, done_cnt);
    end
  endtask

  task automatic test_basic();
    logic [7:0]  vin [4] = '{8'd0, 8'd99, 8'd128, 8'd255};
    logic [11:0] vexp[4] = '{12'h000, 12'h099, 12'h128, 12'h255};
    int cyc; bit bok, hok;
    for (int k = 0; k < 4; k++) begin
      start_conv(vin[k]);
      wait_done(20, cyc, bok, hok);
      n_cmp++;
      if (cyc != 8) begin
        n_err++; $display("FAIL basic_latency[%0d]: %0d edges required 8", vin[k], cyc);
      end
      n_cmp++;
      if ({hundreds, tens, ones} !== vexp[k]) begin
        n_err++; $display("FAIL basic_digits[%0d]: %h required %h", vin[k], {hundreds, tens, ones}, vexp[k]);
      end
      n_cmp++;
      if (!bok) begin
        n_err++; $display("FAIL basic_busy[%0d]: busy wrong during conversion, required high until done", vin[k]);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin
        n_err++; $display("FAIL basic_pulse[%0d]: done=%b one cycle later, required 0", vin[k], done);
      end
    end
  endtask

  task automatic test_stability();
    int cyc, d_before; bit bok, hok;
    d_before = done_cnt;
    start_conv(8'd37);
    repeat (2) @(negedge clk);
    bin = 8'd200;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(20, cyc, bok, hok);
    n_cmp++;
    if (cyc != 3) begin
      n_err++; $display("FAIL stab_latency: %0d more edges required 3", cyc);
    end
    n_cmp++;
    if ({hundreds, tens, ones} !== 12'h037) begin
      n_err++; $display("FAIL stab_digits: %h required 037", {hundreds, tens, ones});
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (done_cnt - d_before != 1 || busy !== 1'b0) begin
      n_err++; $display("FAIL stab_single: dones=%0d busy=%b required 1 0", done_cnt - d_before, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] vexp[3] = '{12'h010, 12'h011, 12'h012};
    int cyc; bit bok, hok;
    bin   = 8'd10;
    start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      wait_done(20, cyc, bok, hok);
      bin = 8'd11 + 8'(k);
      if (k == 2) start = 1'b0;
      n_cmp++;
      if (cyc != ((k == 0) ? 8 : 9)) begin
        n_err++; $display("FAIL b2b_period[%0d]: %0d required %0d", k, cyc, (k == 0) ? 8 : 9);
      end
      n_cmp++;
      if ({hundreds, tens, ones} !== vexp[k]) begin
        n_err++; $display("FAIL b2b_digits[%0d]: %h required %h", k, {hundreds, tens, ones}, vexp[k]);
      end
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL b2b_stop: busy=%b required 0", busy);
    end
  endtask

  task automatic test_abort();
    int cyc, d_before; bit bok, hok;
    start_conv(8'd255);
    repeat (4) @(negedge clk);
    d_before = done_cnt;
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, hundreds, tens, ones} !== 14'h0) begin
      n_err++; $display("FAIL abort_reset: busy/done/digits=%h required 0", {busy, done, hundreds, tens, ones});
    end
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (12) @(negedge clk);
    n_cmp++;
    if (done_cnt != d_before || {hundreds, tens, ones} !== 12'h000) begin
      n_err++; $display("FAIL abort_nodone: dones=%0d digits=%h required 0 000",
                        done_cnt - d_before, {hundreds, tens, ones});
    end
    start_conv(8'd42);
    wait_done(20, cyc, bok, hok);
    n_cmp++;
    if (!hok) begin
      n_err++; $display("FAIL abort_hold: digits changed before done, required 000 held");
    end
    n_cmp++;
    if (cyc != 8 || {hundreds, tens, ones} !== 12'h042) begin
      n_err++; $display("FAIL abort_digits: %h after %0d edges required 042 after 8",
                        {hundreds, tens, ones}, cyc);
    end
  endtask

  task automatic test_auto();
    logic [7:0] q[$];
    logic [7:0] e;
    logic [11:0] expd;
    bit seen255 = 1'b0;
    bit wrap_ok = 1'b0;
    int ndone = 0;
    auto_bin = 8'd0;
    for (int c = 0; c < 5200; c++) begin
      @(negedge clk);
      if (a_done === 1'b1 && q.size() >= 8) begin
        e    = q[q.size() - 8];
        expd = {4'(e / 100), 4'((e / 10) % 10), 4'(e % 10)};
        ndone++;
        n_cmp++;
        if ({a_hundreds, a_tens, a_ones} !== expd) begin
          n_err++; $display("FAIL auto_digits[%0d]: %h required %h", e, {a_hundreds, a_tens, a_ones}, expd);
        end
        if (seen255 && {a_hundreds, a_tens, a_ones} === 12'h000) wrap_ok = 1'b1;
        seen255 = ({a_hundreds, a_tens, a_ones} === 12'h255);
      end
      q.push_back(auto_bin);
      if (c % 20 == 19) auto_bin = auto_bin + 8'd1;
    end
    n_cmp++;
    if (ndone < 570) begin
      n_err++; $display("FAIL auto_rate: %0d conversions required at least 570", ndone);
    end
    n_cmp++;
    if (!wrap_ok) begin
      n_err++; $display("FAIL auto_wrap: 255 then 0 sequence not seen, required 255 -> 000");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stability();
    test_back_to_back();
    test_abort();
    test_auto();
    n_cmp++;
    if (overlap) begin
      n_err++; $display("FAIL done_busy_overlap: seen=1 required 0");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/count_bcd_converter.md
# count_bcd_converter

Sequential binary-to-BCD converter that consumes the 8-bit count from the ripple counter and produces three decimal digits (hundreds, tens, ones) for the display stage. It uses an iterative shift-and-add-3 (double-dabble) datapath: one shift per clock, eight shifts per conversion, with a start/busy/done handshake. An optional free-running mode re-samples the counter after every completed conversion, so the display tracks the count without an external controller.

## Interface
- `AUTO`, default 0: 1 means the block starts a new conversion automatically from IDLE every cycle, ignoring `start`; 0 means conversions begin only on `start`.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low. 0 forces the reset state immediately; release is synchronous to `clk`.
- `bin` input, 8 bits: binary value (counter `q`), sampled only on the accepting edge.
- `start` input, 1 bit: conversion request, sampled in IDLE only.
- `busy` output, 1 bit: high while in SHIFT.
- `done` output, 1 bit: single-cycle pulse when new digits are valid.
- `hundreds` output, 4 bits: BCD hundreds digit, 0..2.
- `tens` output, 4 bits: BCD tens digit, 0..9.
- `ones` output, 4 bits: BCD ones digit, 0..9.

## Operation
- States: IDLE and SHIFT. Internal registers: 8-bit shift register `sr`, 12-bit BCD scratch `acc`, 3-bit shift counter `cnt`.
- **IDLE:**
  - A conversion is accepted when `start`=1, or always when `AUTO`=1.
  - Accepting edge: `sr`<=`bin`, `acc`<=0, `cnt`<=0, state<=SHIFT.
  - Otherwise all registers hold.
- **SHIFT, each edge:**
  - For each nibble of `acc`, add 3 if the nibble is >=5. This correction is combinational on the current `acc`.
  - Then shift `{acc, sr}` left by 1; the MSB of `sr` enters bit 0 of `acc`.
  - `cnt` increments.
- **Completion:** on the edge where `cnt`=7, the shifted result is written directly to `hundreds`/`tens`/`ones`, `done`<=1, and state<=IDLE.
- **Hold and accept rules:**
  - Digit outputs change only on a completion edge and hold between completions.
  - `start` while busy is ignored and is not queued.
  - `start`=1 in the cycle `done` is high is accepted, because the state is already IDLE.
- **Input capture:** `bin` is captured once, so changes to `bin` during SHIFT do not affect the result in flight.
- **Range:** inputs 0..255 give `hundreds` 0..2. The upper 2 bits of `hundreds` are always 0; no overflow is possible.
- **Reset (`reset`=0), at any time including mid-conversion:**
  - State goes to IDLE; `sr`, `acc` and `cnt` go to 0.
  - Outputs: `busy`=0, `done`=0, `hundreds`=`tens`=`ones`=0.
  - The aborted conversion produces no `done`.

## Timing
- Accepting edge E0, where `start` is seen high in IDLE:
  - `busy` is high from just after E0 until just after E8.
  - `done` is high for exactly one cycle, between E8 and E9.
  - New digits are valid from E8 onward.
- Latency from `start` sampled to `done` high: 8 clocks.
- Throughput:
  - `AUTO`=0 with `start` held high: one conversion per 9 clocks.
  - `AUTO`=1: one conversion per 9 clocks; the IDLE cycle after completion is itself the next accepting edge.
- `done` and `busy` are never high in the same cycle.
- Outputs are registered only, with no combinational path from inputs to outputs.
- Clock or reset removed with no conversion in flight: outputs hold their values.

## Test plan
- **Reset value:**
  - Stimulus: assert `reset`=0 for 10 ns at time 10, with no clock edge needed.
  - Required: `busy`=0, `done`=0, digits 0/0/0 immediately.
  - After release, with `start`=0 for 20 cycles: no change.
- **Basic conversions (`AUTO`=0):**
  - Stimulus: `bin`=0, 99, 128, 255, each with a 1-cycle `start`.
  - Required digits: 0/0/0, 0/9/9, 1/2/8, 2/5/5.
  - Required timing: `done` exactly 8 edges after each accepting edge, and high for 1 cycle.
- **Input stability and ignored start:**
  - Stimulus: start with `bin`=37, change `bin` to 200 at cycle 3, pulse `start` at cycle 5.
  - Required: result 0/3/7, a single `done`, and no second conversion.
- **Back-to-back:**
  - Stimulus: `start` held high, `bin` stepping 10, 11, 12 on each `done`.
  - Required: `done` every 9 cycles with results 0/1/0, 0/1/1, 0/1/2.
- **Abort:**
  - Stimulus: start with `bin`=255, assert `reset`=0 after the 4th shift, release, then start with `bin`=42.
  - Required: no `done` for the aborted conversion; digits 0/0/0 until the second conversion completes with 0/4/2.
- **AUTO mode with counter:**
  - Stimulus: `AUTO`=1, `bin` driven by the 8-bit counter incrementing every 20 cycles from 0.
  - Required: every `done` shows digits equal to the counter value captured 8 cycles earlier.
  - Required: wrap from 255 to 0 reads 2/5/5 then 0/0/0.
